// File: rtl/mux_4x_nbit.sv
// 4-to-1 N-bit multiplexer: combinational result plus an enable-gated
// registered copy with select capture and a one-cycle valid strobe.

module mux_4x_nbit_lane (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] sel,
    output logic       y
);
    always_comb begin
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            2'b11:   y = d;
            default: y = 1'bx;  // unknown select propagates in simulation
        endcase
    end
endmodule

module mux_4x_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [1:0]   sel,
    input  logic         en,
    output logic [N-1:0] y,
    output logic [N-1:0] y_q,
    output logic [1:0]   sel_q,
    output logic         valid,
    output logic [3:0]   sel_onehot
);
    for (genvar i = 0; i < N; i++) begin : g_lane
        mux_4x_nbit_lane u_lane (
            .a  (a[i]),
            .b  (b[i]),
            .c  (c[i]),
            .d  (d[i]),
            .sel(sel),
            .y  (y[i])
        );
    end

    assign sel_onehot = 4'b0001 << sel;

    // valid mirrors the enable of the previous edge; data holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            sel_q <= 2'b00;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                y_q   <= y;
                sel_q <= sel;
            end
        end
    end
endmodule

// File: tb/tb_mux_4x_nbit.sv
// Randomised and directed checks of mux_4x_nbit against a queue-based model,
// with N = 8 as the main instance and N = 1 / N = 32 width boundaries.

module tb_mux_4x_nbit;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        en;

    logic [7:0]  a, b, c, d, y, y_q;
    logic [1:0]  sel_q;
    logic        valid;
    logic [3:0]  sel_onehot;

    logic [0:0]  a1, b1, c1, d1, y1, yq1;
    logic [1:0]  selq1;
    logic        v1;
    logic [3:0]  oh1;

    logic [31:0] a32, b32, c32, d32, y32, yq32;
    logic [1:0]  selq32;
    logic        v32;
    logic [3:0]  oh32;

    int vectors = 0;
    int miscompares = 0;

    mux_4x_nbit #(.N(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .sel(sel), .en(en),
        .y(y), .y_q(y_q), .sel_q(sel_q), .valid(valid), .sel_onehot(sel_onehot)
    );

    mux_4x_nbit #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel), .en(en),
        .y(y1), .y_q(yq1), .sel_q(selq1), .valid(v1), .sel_onehot(oh1)
    );

    mux_4x_nbit #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .c(c32), .d(d32), .sel(sel), .en(en),
        .y(y32), .y_q(yq32), .sel_q(selq32), .valid(v32), .sel_onehot(oh32)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] w0,
                                         input logic [31:0] w1, input logic [31:0] w2,
                                         input logic [31:0] w3);
        logic [31:0] words [4];
        words = '{w0, w1, w2, w3};
        return words[s];
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] tbl [4];
        tbl = '{4'd1, 4'd2, 4'd4, 4'd8};
        return tbl[s];
    endfunction

    // Model: history of loads since the last reset; y_q is the newest entry.
    logic [9:0] loads [$];
    logic       m_valid = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            loads.delete();
            m_valid <= 1'b0;
        end else begin
            m_valid <= en;
            if (en) begin
                loads.push_back({sel, 8'(pick(sel, 32'(a), 32'(b), 32'(c), 32'(d)))});
                if (loads.size() > 8) void'(loads.pop_front());
            end
        end
    end

    function automatic logic [9:0] m_last();
        return (loads.size() == 0) ? 10'd0 : loads[loads.size()-1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_y [4];
        logic [9:0] last;
        exp_y = '{8'd200, 8'd122, 8'd255, 8'd17};
        rst = 1'b1; en = 1'b0; sel = 2'b00;
        a = 8'd200; b = 8'd122; c = 8'd255; d = 8'd17;
        a1 = '0; b1 = '0; c1 = '0; d1 = '0;
        a32 = '0; b32 = '0; c32 = '0; d32 = '0;

        #12;
        chk("reset y_q", 32'(y_q), 32'd0);
        chk("reset sel_q", 32'(sel_q), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);

        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("comb y", 32'(y), 32'(exp_y[s]));
            chk("comb onehot", 32'(sel_onehot), 32'(4'b0001 << s));
        end

        sel = 2'b10; #1;
        c = 8'd3; #1;
        chk("track y", 32'(y), 32'd3);
        chk("track y_q", 32'(y_q), 32'd0);
        c = 8'd255;

        @(negedge clk);
        rst = 1'b0; en = 1'b1; sel = 2'b01; b = 8'd122;
        @(posedge clk); #1;
        en = 1'b0;
        chk("load y_q", 32'(y_q), 32'd122);
        chk("load sel_q", 32'(sel_q), 32'd1);
        chk("load valid", 32'(valid), 32'd1);
        @(posedge clk); #1;
        chk("idle valid", 32'(valid), 32'd0);
        chk("idle y_q", 32'(y_q), 32'd122);

        sel = 2'b11; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        chk("pre-rst y_q", 32'(y_q), 32'd17);
        #2 rst = 1'b1;
        #1;
        chk("async y_q", 32'(y_q), 32'd0);
        chk("async sel_q", 32'(sel_q), 32'd0);
        chk("async valid", 32'(valid), 32'd0);
        sel = 2'b00; #1;
        chk("rst y follows", 32'(y), 32'd200);
        @(posedge clk); #1;
        chk("rst hold y_q", 32'(y_q), 32'd0);

        @(negedge clk);
        rst = 1'b0; en = 1'b1; sel = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("stream y_q", 32'(y_q), 32'(exp_y[i]));
            chk("stream valid", 32'(valid), 32'd1);
            sel = 2'(i + 1);
        end
        en = 1'b0;

        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < 4; s++) begin
                a1 = (p == 0) ? 1'b1 : 1'b0;  b1 = (p == 1) ? 1'b1 : 1'b0;
                c1 = (p == 2) ? 1'b1 : 1'b0;  d1 = (p == 3) ? 1'b1 : 1'b0;
                a32 = (p == 0) ? '1 : '0;     b32 = (p == 1) ? '1 : '0;
                c32 = (p == 2) ? '1 : '0;     d32 = (p == 3) ? '1 : '0;
                sel = 2'(s); en = 1'b1;
                #1;
                chk("w1 y", 32'(y1), (p == s) ? 32'd1 : 32'd0);
                chk("w32 y", y32, (p == s) ? 32'hffff_ffff : 32'd0);
                @(posedge clk); #1;
                chk("w1 y_q", 32'(yq1), (p == s) ? 32'd1 : 32'd0);
                chk("w32 y_q", yq32, (p == s) ? 32'hffff_ffff : 32'd0);
            end
        end

        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            a32 = $urandom; b32 = $urandom; c32 = $urandom; d32 = $urandom;
            sel = 2'($urandom); en = 1'($urandom);
            rst = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            last = m_last();
            chk("rnd y", 32'(y), pick(sel, 32'(a), 32'(b), 32'(c), 32'(d)));
            chk("rnd y32", y32, pick(sel, a32, b32, c32, d32));
            chk("rnd onehot", 32'(sel_onehot), 32'(onehot(sel)));
            chk("rnd y_q", 32'(y_q), 32'(last[7:0]));
            chk("rnd sel_q", 32'(sel_q), 32'(last[9:8]));
            chk("rnd valid", 32'(valid), 32'(m_valid));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mux_4x_nbit.md
# mux_4x_nbit

Parameterised 4-to-1 multiplexer selecting one of four N-bit data words by a 2-bit select code. Provides a zero-latency combinational output `y` plus a registered, enable-gated copy `y_q` with a valid strobe, so it can serve both as glue logic and as a pipeline stage in datapaths such as the hex seven-segment display path.

## Interface
- `N`: default 8. Data word width; legal range N ≥ 1.
- `clk`  input  1  rising-edge clock for the registered path.
- `rst`  input  1  asynchronous, active-high reset; clears all registered outputs.
- `a`  input  N  data input, selected when sel = 2'b00.
- `b`  input  N  data input, selected when sel = 2'b01.
- `c`  input  N  data input, selected when sel = 2'b10.
- `d`  input  N  data input, selected when sel = 2'b11.
- `sel`  input  2  select code.
- `en`  input  1  load enable for the registered path.
- `y`  output  N  combinational mux result.
- `y_q`  output  N  registered mux result.
- `sel_q`  output  2  select code captured with `y_q`.
- `valid`  output  1  high for the cycle after a load; indicates `y_q` was just updated.
- `sel_onehot`  output  4  combinational one-hot decode of `sel`; bit i set when sel = i.

## Operation
- Combinational path:
  - sel 00 → y = a; 01 → y = b; 10 → y = c; 11 → y = d.
  - Pure function of current inputs; no clock or reset dependence.
  - Full-width pass-through; no truncation, sign or zero extension.
- `sel_onehot` = 4'b0001 << sel. Exactly one bit is set for every defined `sel`.
- Registered path, on each rising `clk` with rst = 0:
  - en = 1: y_q ← y, sel_q ← sel, valid ← 1.
  - en = 0: y_q and sel_q hold their values; valid ← 0.
- X/Z on `sel`: `y` is don't-care in simulation. The registered path must not latch; behaviour is synthesis-defined.
- No state machine beyond the three registers.

## Timing
- `y` and `sel_onehot`: zero clock latency. They settle within combinational delay of any change on a, b, c, d or sel.
- `y_q`, `sel_q`, `valid`: one-cycle latency from the clock edge at which `en` is sampled high.
- Reset:
  - Asserting `rst` immediately forces y_q = 0, sel_q = 2'b00 and valid = 0, independent of `clk`.
  - These values hold while `rst` stays high.
  - The first load occurs on the first rising edge after deassertion with en = 1.
- Reset mid-operation discards any pending capture. The combinational `y` is unaffected by reset.
- Inputs changing between clock edges affect only `y`. `y_q` reflects the values present at the sampling edge.
- Back-to-back en = 1 updates every cycle; `valid` stays high continuously.

## Test plan
- Combinational select, N = 8, a = 200, b = 122, c = 255, d = 17: step sel through 00, 01, 10, 11 at 1 µs intervals. Required: y = 200, 122, 255, 17, and sel_onehot = 0001, 0010, 0100, 1000.
- Input tracking: sel = 10, then change c from 255 to 3 with no clock edge. Required: y = 3 immediately; y_q unchanged.
- Registered load: rst pulse, then en = 1, sel = 01, b = 122 at a rising edge. Required: next cycle y_q = 122, sel_q = 01, valid = 1. One following cycle with en = 0 → valid = 0, y_q stays 122.
- Async reset: with y_q = 17, assert rst between clock edges. Required: y_q = 0, sel_q = 00 and valid = 0 at once, without waiting for a clock edge. `y` continues to follow sel.
- Streaming: en held high while sel cycles 00→11 over 4 edges. Required: y_q = 200, 122, 255, 17, each lagging by one cycle, with valid high throughout.
- Width boundaries: N = 1 and N = 32. Drive all-ones on one input and zeros on the others, sweeping sel. Required: only the selected position yields all-ones on both y and y_q.
